// File: rtl/c_stack_lsu.sv
// Stack-pointer-relative RVC load/store unit (c.lwsp/c.swsp, plus c.ldsp/c.sdsp on RV64).
// Performs one RAM access per accepted instruction and reports illegal, misaligned and timeout outcomes.
module c_stack_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
)(
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic [15:0]       iIR,
  output logic [4:0]        oRS1,
  output logic [4:0]        oRS2,
  input  logic [XLEN-1:0]   iRS1,
  input  logic [XLEN-1:0]   iRS2,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [XLEN-1:0]   oRAM_DATA,
  input  logic [XLEN-1:0]   iRAM_DATA,
  input  logic              iRAM_ACK,
  output logic              oRD_WE,
  output logic [4:0]        oRD,
  output logic [XLEN-1:0]   oRD_DATA,
  output logic              oDONE,
  output logic              oILLEGAL,
  output logic              oMISALIGNED,
  output logic              oBUS_ERR
);
  localparam int SHIFT = (XLEN == 64) ? 3 : 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                load_q;
  logic                ce_q, ram_rd_q, ram_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     rd_data_q;
  logic                rd_we_q, done_q, ill_q, mis_q, berr_q;

  // Decode of the instruction presented in the accept cycle
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] uimm_d, ea_d;
  logic            is_load_d, is_dbl_d, illegal_d, misal_d;
  logic [ADDR_W-1:0] addr_d;

  assign rd_idx = iIR[11:7];

  always_comb begin
    uimm_d    = '0;
    is_load_d = 1'b0;
    is_dbl_d  = 1'b0;
    illegal_d = 1'b1;
    if (iIR[1:0] == 2'b10) begin
      case (iIR[15:13])
        3'b010: begin
          uimm_d[7:0] = {iIR[3:2], iIR[12], iIR[6:4], 2'b00};
          is_load_d   = 1'b1;
          illegal_d   = (rd_idx == 5'd0);
        end
        3'b110: begin
          uimm_d[7:0] = {iIR[8:7], iIR[12:9], 2'b00};
          illegal_d   = 1'b0;
        end
        3'b011: if (XLEN == 64) begin
          uimm_d[8:0] = {iIR[4:2], iIR[12], iIR[6:5], 3'b000};
          is_load_d   = 1'b1;
          is_dbl_d    = 1'b1;
          illegal_d   = (rd_idx == 5'd0);
        end
        3'b111: if (XLEN == 64) begin
          uimm_d[8:0] = {iIR[9:7], iIR[12:10], 3'b000};
          is_dbl_d    = 1'b1;
          illegal_d   = 1'b0;
        end
        default: ;
      endcase
    end
    ea_d    = iRS1 + uimm_d;
    misal_d = is_dbl_d ? (ea_d[2:0] != 3'd0) : (ea_d[1:0] != 2'd0);
    addr_d  = ADDR_W'(ea_d >> SHIFT);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      ce_q      <= 1'b0;
      ram_rd_q  <= 1'b0;
      ram_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      // Completion strobes and flags live for the single DONE cycle only
      done_q  <= 1'b0;
      rd_we_q <= 1'b0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (iVALID) begin
          rd_q <= rd_idx;
          if (illegal_d || misal_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ill_q   <= illegal_d;
            mis_q   <= !illegal_d && misal_d;
          end else begin
            state_q  <= S_ACCESS;
            cnt_q    <= '0;
            load_q   <= is_load_d;
            ce_q     <= 1'b1;
            ram_rd_q <= is_load_d;
            ram_wr_q <= !is_load_d;
            addr_q   <= addr_d;
            wdata_q  <= is_load_d ? '0 : iRS2;
          end
        end
        S_ACCESS: begin
          if (iRAM_ACK || cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            ce_q     <= 1'b0;
            ram_rd_q <= 1'b0;
            ram_wr_q <= 1'b0;
            if (iRAM_ACK) begin
              if (load_q) begin
                rd_data_q <= iRAM_DATA;
                rd_we_q   <= 1'b1;
              end
            end else begin
              berr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oREADY      = (state_q == S_IDLE);
  assign oRS1        = 5'h2;
  assign oRS2        = iIR[6:2];
  assign oRAM_CE     = ce_q;
  assign oRAM_RD     = ram_rd_q;
  assign oRAM_WR     = ram_wr_q;
  assign oRAM_ADDR   = addr_q;
  assign oRAM_DATA   = wdata_q;
  assign oRD_WE      = rd_we_q;
  assign oRD         = rd_q;
  assign oRD_DATA    = rd_data_q;
  assign oDONE       = done_q;
  assign oILLEGAL    = ill_q;
  assign oMISALIGNED = mis_q;
  assign oBUS_ERR    = berr_q;
endmodule

// File: tb/tb_c_stack_lsu.sv
// Table-driven bench for c_stack_lsu: one XLEN=32 and one XLEN=64 instance sharing stimulus.
// Each unit has its own iVALID; observed outputs are muxed by sel.
module tb_c_stack_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld32, vld64, sel;
  logic [15:0] iIR;
  logic [63:0] iRS1, iRS2, iRAM_DATA;
  logic        iRAM_ACK;

  logic        r32, ce32, rd32, wr32, we32, dn32, il32, ms32, be32;
  logic [4:0]  rs1_32, rs2_32, rdi32;
  logic [7:0]  ad32;
  logic [31:0] wd32, rdd32;
  logic        r64, ce64, rd64, wr64, we64, dn64, il64, ms64, be64;
  logic [4:0]  rs1_64, rs2_64, rdi64;
  logic [7:0]  ad64;
  logic [63:0] wd64, rdd64;

  logic        m_ready, m_ce, m_rd, m_wr, m_we, m_done, m_ill, m_mis, m_berr;
  logic [4:0]  m_rs1, m_rs2, m_rdidx;
  logic [7:0]  m_addr;
  logic [63:0] m_wdata, m_rddata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_stack_lsu #(.XLEN(32), .ADDR_W(8), .TIMEOUT(16)) u32 (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(vld32), .oREADY(r32), .iIR(iIR),
    .oRS1(rs1_32), .oRS2(rs2_32), .iRS1(iRS1[31:0]), .iRS2(iRS2[31:0]),
    .oRAM_CE(ce32), .oRAM_RD(rd32), .oRAM_WR(wr32), .oRAM_ADDR(ad32), .oRAM_DATA(wd32),
    .iRAM_DATA(iRAM_DATA[31:0]), .iRAM_ACK(iRAM_ACK), .oRD_WE(we32), .oRD(rdi32),
    .oRD_DATA(rdd32), .oDONE(dn32), .oILLEGAL(il32), .oMISALIGNED(ms32), .oBUS_ERR(be32));

  c_stack_lsu #(.XLEN(64), .ADDR_W(8), .TIMEOUT(16)) u64 (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(vld64), .oREADY(r64), .iIR(iIR),
    .oRS1(rs1_64), .oRS2(rs2_64), .iRS1(iRS1), .iRS2(iRS2),
    .oRAM_CE(ce64), .oRAM_RD(rd64), .oRAM_WR(wr64), .oRAM_ADDR(ad64), .oRAM_DATA(wd64),
    .iRAM_DATA(iRAM_DATA), .iRAM_ACK(iRAM_ACK), .oRD_WE(we64), .oRD(rdi64),
    .oRD_DATA(rdd64), .oDONE(dn64), .oILLEGAL(il64), .oMISALIGNED(ms64), .oBUS_ERR(be64));

  always_comb begin
    if (sel) begin
      {m_ready, m_ce, m_rd, m_wr, m_we, m_done, m_ill, m_mis, m_berr} =
        {r64, ce64, rd64, wr64, we64, dn64, il64, ms64, be64};
      m_rs1 = rs1_64; m_rs2 = rs2_64; m_rdidx = rdi64; m_addr = ad64;
      m_wdata = wd64; m_rddata = rdd64;
    end else begin
      {m_ready, m_ce, m_rd, m_wr, m_we, m_done, m_ill, m_mis, m_berr} =
        {r32, ce32, rd32, wr32, we32, dn32, il32, ms32, be32};
      m_rs1 = rs1_32; m_rs2 = rs2_32; m_rdidx = rdi32; m_addr = ad32;
      m_wdata = {32'h0, wd32}; m_rddata = {32'h0, rdd32};
    end
  end

  typedef struct {
    logic        sel;
    logic [15:0] ir;
    logic [63:0] rs1, rs2, rdata;
    int          ack_dly;   // ACCESS cycles before ACK; -1 means never
    int          done_cyc, ce_cyc;
    logic        ill, mis, berr, we, load;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rd_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic rst_chk(input string name);
    chk({name, "_strb"}, {56'h0, m_ce, m_rd, m_wr, m_we, m_done, m_ill, m_mis, m_berr}, 64'h0);
    chk({name, "_addr"}, {51'h0, m_addr, m_rdidx}, 64'h0);
    chk({name, "_wdata"}, m_wdata, 64'h0);
    chk({name, "_rddata"}, m_rddata, 64'h0);
    chk({name, "_ready"}, {63'h0, m_ready}, 64'h1);
  endtask

  task automatic run(input vec_t v, input int idx);
    int done_at, ce_n, bad;
    logic ill, mis, berr, we;
    logic [4:0] rd;
    logic [63:0] rdd;
    string t;
    t = $sformatf("v%0d", idx);
    sel = v.sel;
    iIR = v.ir; iRS1 = v.rs1; iRS2 = v.rs2; iRAM_DATA = v.rdata; iRAM_ACK = 1'b0;
    if (v.sel) vld64 = 1'b1; else vld32 = 1'b1;
    #1;
    chk({t, "_ready_pre"}, {63'h0, m_ready}, 64'h1);
    chk({t, "_rs_idx"}, {54'h0, m_rs1, m_rs2}, {54'h0, 5'h2, v.ir[6:2]});
    @(posedge clk); #1;
    vld32 = 1'b0; vld64 = 1'b0;
    done_at = -1; ce_n = 0; bad = 0;
    {ill, mis, berr, we} = 4'b0; rd = '0; rdd = '0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      iRAM_ACK = (v.ack_dly >= 0 && c == v.ack_dly + 1);
      @(negedge clk);
      if (m_ce) begin
        ce_n++;
        if (m_rd !== v.load || m_wr !== !v.load || m_addr !== v.addr || m_wdata !== v.wdata) bad++;
      end else if (m_rd || m_wr) bad++;
      if (m_done) begin
        done_at = c;
        {ill, mis, berr, we} = {m_ill, m_mis, m_berr, m_we};
        rd = m_rdidx; rdd = m_rddata;
      end
      @(posedge clk); #1;
    end
    iRAM_ACK = 1'b0;
    chk({t, "_done_cyc"}, 64'(done_at), 64'(v.done_cyc));
    chk({t, "_ce_cyc"}, 64'(ce_n), 64'(v.ce_cyc));
    chk({t, "_ram_bad"}, 64'(bad), 64'h0);
    chk({t, "_flags"}, {60'h0, ill, mis, berr, we}, {60'h0, v.ill, v.mis, v.berr, v.we});
    if (v.we) begin
      chk({t, "_rd"}, {59'h0, rd}, {59'h0, v.rd});
      chk({t, "_rd_data"}, rdd, v.rd_data);
    end
    @(negedge clk);
    chk({t, "_post"}, {62'h0, m_ready, m_done}, 64'h2);
    @(posedge clk); #1;
  endtask

  initial begin
    int dn_seen;
    rst_n = 1'b0; vld32 = 1'b0; vld64 = 1'b0; sel = 1'b0;
    iIR = '0; iRS1 = '0; iRS2 = '0; iRAM_DATA = '0; iRAM_ACK = 1'b0;

    //                sel ir       rs1                   rs2                    rdata                  dly dn ce il ms be we ld addr   wdata                  rd rd_data
    vecs[0]  = '{1'b0, 16'hC42A, 64'h40,               64'hDEADBEEF,          64'h0,                  0,  2, 1, 0,0,0,0,0, 8'h12, 64'hDEADBEEF,         5'd0, 64'h0};
    vecs[1]  = '{1'b0, 16'h42B2, 64'h40,               64'h0,                 64'h12345678,           2,  4, 3, 0,0,0,1,1, 8'h13, 64'h0,                5'd5, 64'h12345678};
    vecs[2]  = '{1'b0, 16'h4032, 64'h40,               64'h0,                 64'h0,                 -1,  1, 0, 1,0,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[3]  = '{1'b0, 16'hC42A, 64'h42,               64'hDEADBEEF,          64'h0,                 -1,  1, 0, 0,1,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[4]  = '{1'b0, 16'h6442, 64'h80,               64'h0,                 64'h0,                 -1,  1, 0, 1,0,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[5]  = '{1'b0, 16'h42B2, 64'h40,               64'h0,                 64'h0,                 -1, 17,16, 0,0,1,0,1, 8'h13, 64'h0,                5'd0, 64'h0};
    vecs[6]  = '{1'b0, 16'hC429, 64'h40,               64'h0,                 64'h0,                 -1,  1, 0, 1,0,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[7]  = '{1'b0, 16'hDF86, 64'hFFFFFF10,         64'hA5A5A5A5,          64'h0,                  1,  3, 2, 0,0,0,0,0, 8'h03, 64'hA5A5A5A5,         5'd0, 64'h0};
    vecs[8]  = '{1'b0, 16'h51FE, 64'h1000,             64'h0,                 64'hCAFEF00D,           0,  2, 1, 0,0,0,1,1, 8'h3F, 64'h0,                5'd3, 64'hCAFEF00D};
    vecs[9]  = '{1'b0, 16'hE002, 64'h40,               64'h0,                 64'h0,                 -1,  1, 0, 1,0,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[10] = '{1'b0, 16'h42B2, 64'h41,               64'h0,                 64'h0,                 -1,  1, 0, 0,1,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[11] = '{1'b0, 16'h4032, 64'h41,               64'h0,                 64'h0,                 -1,  1, 0, 1,0,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[12] = '{1'b1, 16'h6442, 64'h80,               64'h0,                 64'h0123456789ABCDEF,   0,  2, 1, 0,0,0,1,1, 8'h12, 64'h0,                5'd8, 64'h0123456789ABCDEF};
    vecs[13] = '{1'b1, 16'hE426, 64'h100,              64'hFEEDFACE01234567,  64'h0,                  1,  3, 2, 0,0,0,0,0, 8'h21, 64'hFEEDFACE01234567, 5'd0, 64'h0};
    vecs[14] = '{1'b1, 16'h6442, 64'h84,               64'h0,                 64'h0,                 -1,  1, 0, 0,1,0,0,0, 8'h00, 64'h0,                5'd0, 64'h0};
    vecs[15] = '{1'b1, 16'hC42A, 64'h44,               64'h1122334455667788,  64'h0,                  0,  2, 1, 0,0,0,0,0, 8'h09, 64'h1122334455667788, 5'd0, 64'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 rst_chk("rst32");
    sel = 1'b1; #1 rst_chk("rst64");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run(vecs[i], i);

    // Reset during an XLEN=64 access: the pending load is dropped with no completion
    sel = 1'b1; iIR = 16'h6442; iRS1 = 64'h80; iRAM_ACK = 1'b0; vld64 = 1'b1;
    @(posedge clk); #1 vld64 = 1'b0;
    @(negedge clk);
    chk("mid_ce", {55'h0, m_ce, m_addr}, {55'h0, 1'b1, 8'h12});
    @(posedge clk); #3 rst_n = 1'b0;
    #1 rst_chk("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    dn_seen = 0;
    iRAM_ACK = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (m_done || m_ce) dn_seen++;
    end
    iRAM_ACK = 1'b0;
    chk("mid_no_done", 64'(dn_seen), 64'h0);
    rst_chk("mid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
